// File: rtl/gemm_tile_sequencer.sv
// Tiled-GEMM sequencer: walks (m, n, k) tile steps, drives A/B/C SRAM addresses and
// aligns MAC valid/clear/last and C write strobes to the data path via a tag delay line.
module gemm_tile_sequencer #(
    parameter int unsigned AddrWidth     = 12,
    parameter int unsigned SizeAddrWidth = 8,
    parameter int unsigned ReadLatency   = 1,
    parameter int unsigned PipeLatency   = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic [SizeAddrWidth-1:0] M_size_i,
    input  logic [SizeAddrWidth-1:0] K_size_i,
    input  logic [SizeAddrWidth-1:0] N_size_i,
    input  logic                     order_i,
    input  logic [AddrWidth-1:0]     a_base_i,
    input  logic [AddrWidth-1:0]     b_base_i,
    input  logic [AddrWidth-1:0]     c_base_i,
    input  logic                     stall_i,
    output logic [AddrWidth-1:0]     sram_a_addr_o,
    output logic [AddrWidth-1:0]     sram_b_addr_o,
    output logic [AddrWidth-1:0]     sram_c_addr_o,
    output logic                     sram_c_we_o,
    output logic                     mac_valid_o,
    output logic                     acc_clr_o,
    output logic                     acc_last_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     err_o
);

    localparam int unsigned ProdWidth = 2 * SizeAddrWidth;
    localparam int unsigned LineDepth = ReadLatency + PipeLatency;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_e;

    typedef struct packed {
        logic                     valid;
        logic                     first;
        logic                     last;
        logic [SizeAddrWidth-1:0] m;
        logic [SizeAddrWidth-1:0] n;
    } tag_t;

    state_e state_q, state_d;

    logic [SizeAddrWidth-1:0] m_size_q, k_size_q, n_size_q;
    logic                     order_q;
    logic [AddrWidth-1:0]     a_base_q, b_base_q, c_base_q;

    logic [SizeAddrWidth-1:0] m_q, n_q, k_q;
    logic [SizeAddrWidth-1:0] m_nx, n_nx, k_nx;
    logic                     m_last_c, n_last_c, k_last_c, final_c;

    logic accept_c, zero_start_c, issue_c, line_empty_c;

    tag_t line_q [LineDepth];
    tag_t tag_in_c;

    logic [ProdWidth-1:0] a_off_c, b_off_c, c_off_c;
    logic [AddrWidth-1:0] a_nx_addr_c, b_nx_addr_c, c_wr_addr_c;
    logic [AddrWidth-1:0] a_addr_q, b_addr_q, c_hold_q;
    logic                 busy_q, done_q, err_q;

    assign k_last_c = (k_q == k_size_q - SizeAddrWidth'(1));
    assign n_last_c = (n_q == n_size_q - SizeAddrWidth'(1));
    assign m_last_c = (m_q == m_size_q - SizeAddrWidth'(1));
    assign final_c  = k_last_c & n_last_c & m_last_c;

    // Step successor: k innermost, then n or m depending on the latched order.
    always_comb begin
        k_nx = k_q + SizeAddrWidth'(1);
        n_nx = n_q;
        m_nx = m_q;
        if (k_last_c) begin
            k_nx = '0;
            if (!order_q) begin
                if (n_last_c) begin
                    n_nx = '0;
                    m_nx = m_q + SizeAddrWidth'(1);
                end else begin
                    n_nx = n_q + SizeAddrWidth'(1);
                end
            end else begin
                if (m_last_c) begin
                    m_nx = '0;
                    n_nx = n_q + SizeAddrWidth'(1);
                end else begin
                    m_nx = m_q + SizeAddrWidth'(1);
                end
            end
        end
    end

    // A/B addresses for the next step; C address for the beat leaving the delay line.
    always_comb begin
        a_off_c     = ProdWidth'(m_nx) * ProdWidth'(k_size_q);
        b_off_c     = ProdWidth'(n_nx) * ProdWidth'(k_size_q);
        c_off_c     = ProdWidth'(line_q[LineDepth-1].m) * ProdWidth'(n_size_q);
        a_nx_addr_c = a_base_q + AddrWidth'(a_off_c) + AddrWidth'(k_nx);
        b_nx_addr_c = b_base_q + AddrWidth'(b_off_c) + AddrWidth'(k_nx);
        c_wr_addr_c = c_base_q + AddrWidth'(c_off_c) + AddrWidth'(line_q[LineDepth-1].n);
    end

    always_comb begin
        tag_in_c.valid = issue_c;
        tag_in_c.first = (k_q == '0);
        tag_in_c.last  = k_last_c;
        tag_in_c.m     = m_q;
        tag_in_c.n     = n_q;
    end

    // The final entry is being consumed this cycle, so only earlier stages count.
    always_comb begin
        line_empty_c = 1'b1;
        for (int i = 0; i < int'(LineDepth) - 1; i++) begin
            if (line_q[i].valid) begin
                line_empty_c = 1'b0;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        accept_c     = 1'b0;
        zero_start_c = 1'b0;
        issue_c      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    if ((M_size_i == '0) || (K_size_i == '0) || (N_size_i == '0)) begin
                        zero_start_c = 1'b1;
                    end else begin
                        accept_c = 1'b1;
                        state_d  = RUN;
                    end
                end
            end
            RUN: begin
                if (!stall_i) begin
                    issue_c = 1'b1;
                    if (final_c) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (!stall_i && line_empty_c) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            m_size_q <= '0;
            k_size_q <= '0;
            n_size_q <= '0;
            order_q  <= 1'b0;
            a_base_q <= '0;
            b_base_q <= '0;
            c_base_q <= '0;
            m_q      <= '0;
            n_q      <= '0;
            k_q      <= '0;
            a_addr_q <= '0;
            b_addr_q <= '0;
            c_hold_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            for (int i = 0; i < int'(LineDepth); i++) begin
                line_q[i] <= '0;
            end
        end else begin
            if (accept_c) begin
                m_size_q <= M_size_i;
                k_size_q <= K_size_i;
                n_size_q <= N_size_i;
                order_q  <= order_i;
                a_base_q <= a_base_i;
                b_base_q <= b_base_i;
                c_base_q <= c_base_i;
                m_q      <= '0;
                n_q      <= '0;
                k_q      <= '0;
                a_addr_q <= a_base_i;
                b_addr_q <= b_base_i;
            end else if (issue_c && !final_c) begin
                m_q      <= m_nx;
                n_q      <= n_nx;
                k_q      <= k_nx;
                a_addr_q <= a_nx_addr_c;
                b_addr_q <= b_nx_addr_c;
            end
            // Stall freezes the tags in place so held read data pairs with its beat.
            if (!stall_i) begin
                line_q[0] <= tag_in_c;
                for (int i = 1; i < int'(LineDepth); i++) begin
                    line_q[i] <= line_q[i-1];
                end
            end
            if (sram_c_we_o) begin
                c_hold_q <= c_wr_addr_c;
            end
            busy_q <= (state_d == RUN) || (state_d == DRAIN);
            done_q <= zero_start_c || ((state_q == DRAIN) && (state_d == DONE));
            err_q  <= zero_start_c;
        end
    end

    assign sram_a_addr_o = a_addr_q;
    assign sram_b_addr_o = b_addr_q;
    assign sram_c_we_o   = line_q[LineDepth-1].valid & line_q[LineDepth-1].last & ~stall_i;
    assign sram_c_addr_o = sram_c_we_o ? c_wr_addr_c : c_hold_q;
    assign mac_valid_o   = line_q[ReadLatency-1].valid & ~stall_i;
    assign acc_clr_o     = mac_valid_o & line_q[ReadLatency-1].first;
    assign acc_last_o    = mac_valid_o & line_q[ReadLatency-1].last;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_gemm_tile_sequencer.sv
// Directed scoreboard bench for gemm_tile_sequencer at ReadLatency=1, PipeLatency=2.
module tb_gemm_tile_sequencer;

    localparam int unsigned AW = 12;
    localparam int unsigned SW = 8;

    logic          clk = 1'b0;
    logic          rst_i, start_i, order_i, stall_i;
    logic [SW-1:0] m_size, k_size, n_size;
    logic [AW-1:0] a_base, b_base, c_base;
    logic [AW-1:0] a_addr, b_addr, c_addr;
    logic          c_we, mac_valid, acc_clr, acc_last, busy, done, err;

    always #5 clk = ~clk;

    gemm_tile_sequencer #(
        .AddrWidth(AW), .SizeAddrWidth(SW), .ReadLatency(1), .PipeLatency(2)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
        .M_size_i(m_size), .K_size_i(k_size), .N_size_i(n_size),
        .order_i(order_i), .a_base_i(a_base), .b_base_i(b_base), .c_base_i(c_base),
        .stall_i(stall_i),
        .sram_a_addr_o(a_addr), .sram_b_addr_o(b_addr), .sram_c_addr_o(c_addr),
        .sram_c_we_o(c_we), .mac_valid_o(mac_valid), .acc_clr_o(acc_clr),
        .acc_last_o(acc_last), .busy_o(busy), .done_o(done), .err_o(err)
    );

    typedef struct { int a; int b; int clr; int last; int cyc; } beat_t;
    typedef struct { int addr; int cyc; } wr_t;
    typedef struct { int cyc; int err; } done_t;

    beat_t beat_q[$];
    wr_t   wr_q[$];
    done_t done_q[$];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int t0 = 0;
    int beat_cnt = 0;
    int wr_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (rel cycle %0d)", name, act, exp, cyc - t0);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rel(input int r);
        while (cyc - t0 < r) tick();
    endtask

    task automatic push_beat(input int a, input int b, input int clr, input int last, input int c);
        beat_t e;
        e.a = a; e.b = b; e.clr = clr; e.last = last; e.cyc = c;
        beat_q.push_back(e);
    endtask

    task automatic push_wr(input int addr, input int c);
        wr_t e;
        e.addr = addr; e.cyc = c;
        wr_q.push_back(e);
    endtask

    task automatic push_done(input int c, input int e_err);
        done_t e;
        e.cyc = c; e.err = e_err;
        done_q.push_back(e);
    endtask

    // Reference traversal: k innermost; order 0 walks m outer, order 1 walks n outer.
    task automatic push_beats(input int ab, input int bb, input int mm, input int kk, input int nn,
                              input int ord, input int first_cyc, input int limit);
        int idx;
        int m;
        int n;
        idx = 0;
        for (int o = 0; o < ((ord != 0) ? nn : mm); o++) begin
            for (int i = 0; i < ((ord != 0) ? mm : nn); i++) begin
                for (int k = 0; k < kk; k++) begin
                    m = (ord != 0) ? i : o;
                    n = (ord != 0) ? o : i;
                    if (idx < limit) begin
                        push_beat((ab + m * kk + k) % 4096, (bb + n * kk + k) % 4096,
                                  (k == 0) ? 1 : 0, (k == kk - 1) ? 1 : 0,
                                  (first_cyc < 0) ? -1 : first_cyc + idx);
                    end
                    idx++;
                end
            end
        end
    endtask

    task automatic start_run(input int mm, input int kk, input int nn, input int ord,
                             input int ab, input int bb, input int cb);
        m_size  = SW'(mm);
        k_size  = SW'(kk);
        n_size  = SW'(nn);
        order_i = ord[0];
        a_base  = AW'(ab);
        b_base  = AW'(bb);
        c_base  = AW'(cb);
        start_i = 1'b1;
        t0       = cyc;
        beat_cnt = 0;
        wr_cnt   = 0;
    endtask

    task automatic end_scn(input string name);
        check({name, "_leftover_beats"}, beat_q.size(), 0);
        check({name, "_leftover_writes"}, wr_q.size(), 0);
        check({name, "_leftover_done"}, done_q.size(), 0);
        beat_q.delete();
        wr_q.delete();
        done_q.delete();
    endtask

    // Monitor: with one read-latency stage, a beat's address is the one shown in the
    // most recent unstalled cycle before the beat appears.
    logic [AW-1:0] last_a = '0, last_b = '0, prev_a = '0, prev_b = '0;
    logic          prev_stall = 1'b0;

    always @(negedge clk) begin
        if (mac_valid) begin : mon_beat
            beat_t e;
            beat_cnt++;
            if (beat_q.size() == 0) begin
                check("unexpected_beat", 1, 0);
            end else begin
                e = beat_q.pop_front();
                check("beat_a_addr", int'(last_a), e.a);
                check("beat_b_addr", int'(last_b), e.b);
                check("beat_acc_clr", int'(acc_clr), e.clr);
                check("beat_acc_last", int'(acc_last), e.last);
                if (e.cyc >= 0) check("beat_cycle", cyc - t0, e.cyc);
            end
        end else if (acc_clr || acc_last) begin
            check("acc_strobe_without_valid", 1, 0);
        end
        if (c_we) begin : mon_wr
            wr_t e;
            wr_cnt++;
            if (wr_q.size() == 0) begin
                check("unexpected_c_write", int'(c_addr), -1);
            end else begin
                e = wr_q.pop_front();
                check("c_write_addr", int'(c_addr), e.addr);
                if (e.cyc >= 0) check("c_write_cycle", cyc - t0, e.cyc);
            end
        end
        if (done) begin : mon_done
            done_t e;
            if (done_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = done_q.pop_front();
                check("done_cycle", cyc - t0, e.cyc);
                check("done_err", int'(err), e.err);
                check("done_busy_low", int'(busy), 0);
            end
        end
        if (err && !done) check("err_without_done", 1, 0);
        if (prev_stall) begin
            check("stall_hold_a", int'(a_addr), int'(prev_a));
            check("stall_hold_b", int'(b_addr), int'(prev_b));
        end
        if (!stall_i) begin
            last_a = a_addr;
            last_b = b_addr;
        end
        prev_stall = stall_i;
        prev_a     = a_addr;
        prev_b     = b_addr;
    end

    task automatic check_all_zero(input string name);
        check({name, "_a"}, int'(a_addr), 0);
        check({name, "_b"}, int'(b_addr), 0);
        check({name, "_c"}, int'(c_addr), 0);
        check({name, "_flags"}, int'({c_we, mac_valid, acc_clr, acc_last, busy, done, err}), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    initial begin
        rst_i = 1'b1; start_i = 1'b0; stall_i = 1'b0; order_i = 1'b0;
        m_size = '0; k_size = '0; n_size = '0;
        a_base = '0; b_base = '0; c_base = '0;
        repeat (3) tick();
        check_all_zero("reset");
        rst_i = 1'b0;
        tick();

        // Minimal 1x1x1 run
        push_beat(0, 0, 1, 1, 2);
        push_wr(0, 4);
        push_done(5, 0);
        start_run(1, 1, 1, 0, 0, 0, 0);
        tick(); start_i = 1'b0;
        check("min_a_t1", int'(a_addr), 0);
        check("min_busy_t1", int'(busy), 1);
        wait_rel(2);
        check("min_mac_valid_t2", int'(mac_valid), 1);
        wait_rel(12);
        end_scn("min");

        // Order 0
        push_beats('h100, 'h200, 2, 3, 2, 0, 2, 1000);
        push_wr('h300, 6); push_wr('h301, 9); push_wr('h302, 12); push_wr('h303, 15);
        push_done(16, 0);
        start_run(2, 3, 2, 0, 'h100, 'h200, 'h300);
        tick(); start_i = 1'b0;
        check("o0_a_t1", int'(a_addr), 'h100);
        check("o0_b_t1", int'(b_addr), 'h200);
        wait_rel(24);
        check("o0_beats", beat_cnt, 12);
        end_scn("o0");

        // Order 1
        push_beats('h100, 'h200, 2, 3, 2, 1, 2, 1000);
        push_wr('h300, 6); push_wr('h302, 9); push_wr('h301, 12); push_wr('h303, 15);
        push_done(16, 0);
        start_run(2, 3, 2, 1, 'h100, 'h200, 'h300);
        tick(); start_i = 1'b0;
        wait_rel(24);
        check("o1_writes", wr_cnt, 4);
        end_scn("o1");

        // Stall 5..7 plus an ignored start at cycle 3
        push_beats('h100, 'h200, 2, 3, 2, 0, -1, 1000);
        push_wr('h300, -1); push_wr('h301, -1); push_wr('h302, -1); push_wr('h303, -1);
        push_done(19, 0);
        start_run(2, 3, 2, 0, 'h100, 'h200, 'h300);
        for (int r = 1; r <= 26; r++) begin
            tick();
            start_i = (r == 3);
            if (r == 3) begin
                m_size = SW'(1); k_size = SW'(1); n_size = SW'(1); order_i = 1'b1;
                a_base = AW'('h7); b_base = AW'('h7); c_base = AW'('h7);
            end
            stall_i = (r >= 5) && (r <= 7);
        end
        check("stall_beats", beat_cnt, 12);
        check("stall_writes", wr_cnt, 4);
        end_scn("stall");

        // Address wrap
        push_beat('hFFE, 0, 1, 0, 2);
        push_beat('hFFF, 1, 0, 0, 3);
        push_beat('h000, 2, 0, 0, 4);
        push_beat('h001, 3, 0, 1, 5);
        push_wr('h050, 7);
        push_done(8, 0);
        start_run(1, 4, 1, 0, 'hFFE, 0, 'h050);
        tick(); start_i = 1'b0;
        wait_rel(16);
        end_scn("wrap");

        // Zero-size start
        push_done(1, 1);
        start_run(2, 0, 2, 0, 'h100, 'h200, 'h300);
        tick(); start_i = 1'b0;
        check("err_busy_t1", int'(busy), 0);
        wait_rel(8);
        check("err_no_beats", beat_cnt, 0);
        check("err_no_writes", wr_cnt, 0);
        end_scn("err");

        // Reset mid-run at cycle 6, then a fresh start at cycle 8
        push_beats('h100, 'h200, 2, 3, 2, 0, 2, 5);
        push_wr('h300, 6);
        start_run(2, 3, 2, 0, 'h100, 'h200, 'h300);
        tick(); start_i = 1'b0;
        wait_rel(6);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check_all_zero("midrst_t7");
        tick();
        check("midrst_beats", beat_cnt, 5);
        check("midrst_writes", wr_cnt, 1);
        end_scn("midrst");
        push_beat('h010, 'h020, 1, 1, 2);
        push_wr('h030, 4);
        push_done(5, 0);
        start_run(1, 1, 1, 0, 'h010, 'h020, 'h030);
        tick(); start_i = 1'b0;
        check("restart_busy_t1", int'(busy), 1);
        wait_rel(12);
        end_scn("restart");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/gemm_tile_sequencer.md
# gemm_tile_sequencer

Parametrised tiled-GEMM address sequencer and MAC-array controller. It sits between `gemm_accelerator_top`'s start/size interface and the single-port SRAMs A, B and C, replacing the fixed-order, fixed-base sequencing of the current controller. Generalised over SRAM read latency, MAC pipeline depth, per-operand base addresses and tile traversal order, with a global stall. It emits one (m, n, k) tile step per unstalled cycle and aligns MAC-valid, accumulator-clear/last and C write strobes to the data path.

## Interface
Parameters:
- `AddrWidth`, 12, SRAM address width; all address arithmetic is modulo 2^AddrWidth.
- `SizeAddrWidth`, 8, width of the tile-count inputs.
- `ReadLatency`, 1, cycles from SRAM address to read data (≥1).
- `PipeLatency`, 2, cycles from the last k beat at MAC input to the result being ready for C (≥1).

Ports:
- `clk_i` in 1: single clock; all logic on the rising edge.
- `rst_i` in 1: reset, synchronous, active-high.
- `start_i` in 1: start request; sampled only in IDLE.
- `M_size_i`, `K_size_i`, `N_size_i` in SizeAddrWidth: tile counts; latched on start.
- `order_i` in 1: traversal order. 0 = m outer, n middle; 1 = n outer, m middle. k is always innermost. Latched on start.
- `a_base_i`, `b_base_i`, `c_base_i` in AddrWidth: base addresses; latched on start.
- `stall_i` in 1: freeze the whole sequencer, including the delay line.
- `sram_a_addr_o`, `sram_b_addr_o`, `sram_c_addr_o` out AddrWidth: SRAM addresses.
- `sram_c_we_o` out 1: C write strobe.
- `mac_valid_o` out 1: A/B read data is valid at the MAC inputs this cycle.
- `acc_clr_o` out 1: the current valid beat is k = 0.
- `acc_last_o` out 1: the current valid beat is k = K−1.
- `busy_o` out 1: high in RUN and DRAIN.
- `done_o` out 1: one-cycle completion pulse.
- `err_o` out 1: one-cycle pulse on a zero-size start; coincides with `done_o`.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - On `start_i` with all sizes nonzero: latch config, clear m/n/k counters, go to RUN.
  - On `start_i` with any size zero: pulse `done_o` and `err_o` next cycle, stay IDLE, issue nothing.
- RUN:
  - Each cycle with `stall_i` low, issue the current step and advance counters.
  - `sram_a_addr_o` = a_base + m·K + k.
  - `sram_b_addr_o` = b_base + n·K + k.
  - After issuing the final step (m=M−1, n=N−1, k=K−1), go to DRAIN.
- Delay line:
  - Tags {valid, k==0, k==K−1, m, n} travel ReadLatency stages to drive `mac_valid_o`, `acc_clr_o` and `acc_last_o`.
  - Beats with last set travel a further PipeLatency stages, then pulse `sram_c_we_o` with `sram_c_addr_o` = c_base + m·N + n. C is always row-major, whatever `order_i` says.
- DRAIN: go to DONE when the delay line holds no valid entries.
- DONE: `done_o` high for one cycle, then IDLE.
- `start_i` outside IDLE is ignored. Config inputs are ignored except on the accepted start.
- Stall (any state):
  - No counter advance and no delay-line shift.
  - `mac_valid_o`, `acc_clr_o`, `acc_last_o` and `sram_c_we_o` forced low.
  - Address outputs hold their values, so SRAM read data stays stable.
  - On release, no beat is dropped or duplicated.
- Address outputs hold their last value when not issuing or writing.
- Reset in any state: return to IDLE, flush the delay line, all outputs 0.

## Timing
- Reset values: all addresses 0; `sram_c_we_o`, `mac_valid_o`, `acc_clr_o`, `acc_last_o`, `busy_o`, `done_o`, `err_o` all 0.
- Start accepted at cycle t:
  - First A/B address at t+1; `busy_o` high from t+1.
  - First `mac_valid_o` at t+1+ReadLatency.
- The last-k beat of a tile is valid at cycle u; its C write occurs at u+PipeLatency.
- With T = M·N·K and no stalls:
  - Issues occupy t+1 … t+T.
  - Final C write at t+T+ReadLatency+PipeLatency.
  - `done_o` at t+T+ReadLatency+PipeLatency+1, with `busy_o` low that cycle.
- Every stalled cycle delays all subsequent events by exactly one cycle.
- Zero-size start at t: `done_o` = `err_o` = 1 at t+1; `busy_o` stays 0.

## Test plan
All scenarios use ReadLatency = 1, PipeLatency = 2, start at cycle 0.
- **Minimal run.** M=K=N=1, bases 0.
  - A/B address 0 at cycle 1.
  - `mac_valid_o`, `acc_clr_o` and `acc_last_o` all high at cycle 2.
  - `sram_c_we_o` at cycle 4 with C address 0.
  - `done_o` at cycle 5.
- **Order 0.** M=2, K=3, N=2, order 0; bases A=0x100, B=0x200, C=0x300.
  - A sequence: 100,101,102, 100,101,102, 103,104,105, 103,104,105.
  - B sequence: 200–202, 203–205, 200–202, 203–205.
  - C writes to 0x300, 0x301, 0x302, 0x303.
  - `done_o` at cycle 16.
- **Order 1.** Same config with order 1.
  - C write order is 0x300, 0x302, 0x301, 0x303.
  - `done_o` at cycle 16.
- **Stall and busy start.**
  - Order-0 config with `stall_i` high for cycles 5–7: exactly 12 valid beats, 4 writes, `done_o` at cycle 19, addresses constant during the stall.
  - A `start_i` pulse at cycle 3 is ignored.
- **Address wrap.** a_base=0xFFE, M=N=1, K=4: A addresses are 0xFFE, 0xFFF, 0x000, 0x001.
- **Error and mid-run reset.**
  - K=0 start: `done_o` and `err_o` at cycle 1, no strobes.
  - `rst_i` at cycle 6 of the order-0 run: all outputs 0 at cycle 7, no further writes, new start accepted at cycle 8.
